// File: rtl/envelope_sequencer.sv
// envelope_sequencer: time-multiplexes one shared double_biquad across the
// analysis bands (BPF pass, rectify, LPF pass per band) and owns all per-band
// filter history. Emits one envelope word per band per accepted sample.
module envelope_sequencer #(
  parameter int NUM_BANDS = 8,
  parameter int BPF_SHIFT = 20,
  parameter int LPF_SHIFT = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] sample_in,
  input  logic        sample_valid_in,
  output logic        ready_out,
  input  logic        hist_clear_in,
  output logic        bq_valid_out,
  output logic [3:0]  bq_coeff_sel_out,
  output logic [4:0]  bq_shift_out,
  output logic [31:0] bq_x_n,
  output logic [31:0] bq_x_n1,
  output logic [31:0] bq_x_n2,
  output logic [31:0] bq_i_n1,
  output logic [31:0] bq_i_n2,
  output logic [31:0] bq_y_n1,
  output logic [31:0] bq_y_n2,
  input  logic [31:0] bq_i_n,
  input  logic [31:0] bq_y_n,
  input  logic        bq_valid_in,
  output logic [31:0] env_out,
  output logic [2:0]  env_band_out,
  output logic        env_valid_out,
  output logic        frame_done_out
);

  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  typedef enum logic [2:0] {IDLE, BPF_ISSUE, BPF_WAIT, LPF_ISSUE, LPF_WAIT, COMMIT} state_t;
  typedef logic [31:0] hist_t [NUM_BANDS];

  // Full-wave rectifier; the most negative value saturates instead of wrapping.
  function automatic logic [31:0] sat_abs(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    else if (v[31])         return 32'd0 - v;
    else                    return v;
  endfunction

  state_t        state_q, state_d;
  logic [BW-1:0] band_q, band_d;
  logic [31:0]   xs_q, xs_d, xh1_q, xh1_d, xh2_q, xh2_d;
  logic [31:0]   bi_q, bi_d, by_q, by_d;
  hist_t         bi1_q, bi1_d, bi2_q, bi2_d, by1_q, by1_d, by2_q, by2_d;
  hist_t         li1_q, li1_d, li2_q, li2_d, ly1_q, ly1_d, ly2_q, ly2_d;
  logic          ready_q, ready_d, bq_valid_q, bq_valid_d;
  logic [3:0]    coeff_q, coeff_d;
  logic [4:0]    shift_q, shift_d;
  logic [31:0]   x_n_q, x_n_d, x_n1_q, x_n1_d, x_n2_q, x_n2_d;
  logic [31:0]   i_n1_q, i_n1_d, i_n2_q, i_n2_d, y_n1_q, y_n1_d, y_n2_q, y_n2_d;
  logic [31:0]   env_q, env_d;
  logic [2:0]    env_band_q, env_band_d;
  logic          env_valid_q, env_valid_d, frame_done_q, frame_done_d;

  logic          issue_bpf;
  logic [BW-1:0] issue_band;
  logic [31:0]   issue_x;
  logic          last_band;

  // Next-state, history and registered-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    band_d       = band_q;
    xs_d         = xs_q;
    xh1_d        = xh1_q;
    xh2_d        = xh2_q;
    bi_d         = bi_q;
    by_d         = by_q;
    bi1_d        = bi1_q;
    bi2_d        = bi2_q;
    by1_d        = by1_q;
    by2_d        = by2_q;
    li1_d        = li1_q;
    li2_d        = li2_q;
    ly1_d        = ly1_q;
    ly2_d        = ly2_q;
    bq_valid_d   = 1'b0;
    coeff_d      = coeff_q;
    shift_d      = shift_q;
    x_n_d        = x_n_q;
    x_n1_d       = x_n1_q;
    x_n2_d       = x_n2_q;
    i_n1_d       = i_n1_q;
    i_n2_d       = i_n2_q;
    y_n1_d       = y_n1_q;
    y_n2_d       = y_n2_q;
    env_d        = env_q;
    env_band_d   = env_band_q;
    env_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    issue_bpf    = 1'b0;
    issue_band   = band_q;
    issue_x      = xs_q;
    last_band    = (band_q == BW'(NUM_BANDS - 1));

    case (state_q)
      IDLE: begin
        if (hist_clear_in) begin
          xh1_d = '0;
          xh2_d = '0;
          bi1_d = '{default: '0};
          bi2_d = '{default: '0};
          by1_d = '{default: '0};
          by2_d = '{default: '0};
          li1_d = '{default: '0};
          li2_d = '{default: '0};
          ly1_d = '{default: '0};
          ly2_d = '{default: '0};
        end else if (sample_valid_in) begin
          xs_d       = sample_in;
          band_d     = '0;
          issue_bpf  = 1'b1;
          issue_band = '0;
          issue_x    = sample_in;
        end
      end
      BPF_ISSUE: state_d = BPF_WAIT;
      BPF_WAIT: begin
        if (bq_valid_in) begin
          bi_d       = bq_i_n;
          by_d       = bq_y_n;
          state_d    = LPF_ISSUE;
          bq_valid_d = 1'b1;
          coeff_d    = 4'(NUM_BANDS);
          shift_d    = 5'(LPF_SHIFT);
          x_n_d      = sat_abs(bq_y_n);
          x_n1_d     = sat_abs(by1_q[band_q]);
          x_n2_d     = sat_abs(by2_q[band_q]);
          i_n1_d     = li1_q[band_q];
          i_n2_d     = li2_q[band_q];
          y_n1_d     = ly1_q[band_q];
          y_n2_d     = ly2_q[band_q];
        end
      end
      LPF_ISSUE: state_d = LPF_WAIT;
      LPF_WAIT: begin
        // History is written on the edge entering COMMIT so the LPF result needs
        // no holding register; nothing reads it during COMMIT itself.
        if (bq_valid_in) begin
          bi2_d[band_q] = bi1_q[band_q];
          bi1_d[band_q] = bi_q;
          by2_d[band_q] = by1_q[band_q];
          by1_d[band_q] = by_q;
          li2_d[band_q] = li1_q[band_q];
          li1_d[band_q] = bq_i_n;
          ly2_d[band_q] = ly1_q[band_q];
          ly1_d[band_q] = bq_y_n;
          env_d         = bq_y_n;
          env_band_d    = 3'(band_q);
          env_valid_d   = 1'b1;
          if (last_band) begin
            xh2_d        = xh1_q;
            xh1_d        = xs_q;
            frame_done_d = 1'b1;
          end
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (last_band) begin
          state_d = IDLE;
        end else begin
          band_d     = band_q + BW'(1);
          issue_bpf  = 1'b1;
          issue_band = band_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_bpf) begin
      state_d    = BPF_ISSUE;
      bq_valid_d = 1'b1;
      coeff_d    = 4'(issue_band);
      shift_d    = 5'(BPF_SHIFT);
      x_n_d      = issue_x;
      x_n1_d     = xh1_q;
      x_n2_d     = xh2_q;
      i_n1_d     = bi1_q[issue_band];
      i_n2_d     = bi2_q[issue_band];
      y_n1_d     = by1_q[issue_band];
      y_n2_d     = by2_q[issue_band];
    end

    ready_d = (state_d == IDLE);
  end

  // State, history and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      band_q       <= '0;
      xs_q         <= '0;
      xh1_q        <= '0;
      xh2_q        <= '0;
      bi_q         <= '0;
      by_q         <= '0;
      bi1_q        <= '{default: '0};
      bi2_q        <= '{default: '0};
      by1_q        <= '{default: '0};
      by2_q        <= '{default: '0};
      li1_q        <= '{default: '0};
      li2_q        <= '{default: '0};
      ly1_q        <= '{default: '0};
      ly2_q        <= '{default: '0};
      ready_q      <= 1'b0;
      bq_valid_q   <= 1'b0;
      coeff_q      <= '0;
      shift_q      <= '0;
      x_n_q        <= '0;
      x_n1_q       <= '0;
      x_n2_q       <= '0;
      i_n1_q       <= '0;
      i_n2_q       <= '0;
      y_n1_q       <= '0;
      y_n2_q       <= '0;
      env_q        <= '0;
      env_band_q   <= '0;
      env_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      band_q       <= band_d;
      xs_q         <= xs_d;
      xh1_q        <= xh1_d;
      xh2_q        <= xh2_d;
      bi_q         <= bi_d;
      by_q         <= by_d;
      bi1_q        <= bi1_d;
      bi2_q        <= bi2_d;
      by1_q        <= by1_d;
      by2_q        <= by2_d;
      li1_q        <= li1_d;
      li2_q        <= li2_d;
      ly1_q        <= ly1_d;
      ly2_q        <= ly2_d;
      ready_q      <= ready_d;
      bq_valid_q   <= bq_valid_d;
      coeff_q      <= coeff_d;
      shift_q      <= shift_d;
      x_n_q        <= x_n_d;
      x_n1_q       <= x_n1_d;
      x_n2_q       <= x_n2_d;
      i_n1_q       <= i_n1_d;
      i_n2_q       <= i_n2_d;
      y_n1_q       <= y_n1_d;
      y_n2_q       <= y_n2_d;
      env_q        <= env_d;
      env_band_q   <= env_band_d;
      env_valid_q  <= env_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready_out        = ready_q;
  assign bq_valid_out     = bq_valid_q;
  assign bq_coeff_sel_out = coeff_q;
  assign bq_shift_out     = shift_q;
  assign bq_x_n           = x_n_q;
  assign bq_x_n1          = x_n1_q;
  assign bq_x_n2          = x_n2_q;
  assign bq_i_n1          = i_n1_q;
  assign bq_i_n2          = i_n2_q;
  assign bq_y_n1          = y_n1_q;
  assign bq_y_n2          = y_n2_q;
  assign env_out          = env_q;
  assign env_band_out     = env_band_q;
  assign env_valid_out    = env_valid_q;
  assign frame_done_out   = frame_done_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: a fixed-latency stub biquad feeds results back,
// a band-level reference model predicts every issue and envelope word.
module tb_envelope_sequencer;
  localparam int NB = 8;
  localparam int L  = 3;
  localparam int BAND_CYC = 2 * L + 3;

  typedef struct packed {
    logic [3:0]  sel;
    logic [4:0]  sh;
    logic [31:0] xn, xn1, xn2, in1, in2, yn1, yn2;
  } issue_t;
  typedef struct packed {
    logic [2:0]  band;
    logic [31:0] val;
  } env_t;
  typedef struct {
    logic [31:0] s;
    logic [31:0] env;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        hist_clear = 1'b0;
  logic        ready_out, bq_valid_out, bq_valid_in, env_valid_out, frame_done_out;
  logic [3:0]  bq_coeff_sel_out;
  logic [4:0]  bq_shift_out;
  logic [31:0] bq_x_n, bq_x_n1, bq_x_n2, bq_i_n1, bq_i_n2, bq_y_n1, bq_y_n2;
  logic [31:0] bq_i_n, bq_y_n, env_out;
  logic [2:0]  env_band_out;

  always #5 clk = ~clk;

  envelope_sequencer #(.NUM_BANDS(NB), .BPF_SHIFT(20), .LPF_SHIFT(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .sample_in(sample_in), .sample_valid_in(sample_valid),
    .ready_out(ready_out), .hist_clear_in(hist_clear), .bq_valid_out(bq_valid_out),
    .bq_coeff_sel_out(bq_coeff_sel_out), .bq_shift_out(bq_shift_out),
    .bq_x_n(bq_x_n), .bq_x_n1(bq_x_n1), .bq_x_n2(bq_x_n2), .bq_i_n1(bq_i_n1),
    .bq_i_n2(bq_i_n2), .bq_y_n1(bq_y_n1), .bq_y_n2(bq_y_n2), .bq_i_n(bq_i_n),
    .bq_y_n(bq_y_n), .bq_valid_in(bq_valid_in), .env_out(env_out),
    .env_band_out(env_band_out), .env_valid_out(env_valid_out), .frame_done_out(frame_done_out)
  );

  // Stub biquad behaviour knobs (written only by the main initial block).
  bit          pass_mode = 1'b1;
  logic [31:0] salt = '0;
  logic [3:0]  ovr_sel = 4'hF;
  logic        spur = 1'b0;

  function automatic logic [63:0] stub_fn(input issue_t r);
    logic [31:0] i, y;
    if (pass_mode) begin
      i = r.xn;
      y = r.xn;
    end else begin
      i = r.xn ^ salt ^ {23'd0, r.sel, r.sh};
      y = r.xn + r.xn1 - r.xn2 + r.in1 - 32'($signed(r.yn2) >>> 2) + salt;
      if (y[4:0] == salt[4:0]) y = 32'h8000_0000;
    end
    if (r.sel == ovr_sel) y = 32'h8000_0000;
    return {i, y};
  endfunction

  function automatic logic [31:0] sabs(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    if ($signed(v) < 0) return 32'd0 - v;
    return v;
  endfunction

  issue_t      cur_issue;
  logic [2:0]  pv;
  logic [63:0] pd [3];
  assign cur_issue = {bq_coeff_sel_out, bq_shift_out, bq_x_n, bq_x_n1, bq_x_n2,
                      bq_i_n1, bq_i_n2, bq_y_n1, bq_y_n2};

  // Stub biquad: L-stage pipeline returning stub_fn of the issued operands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv    <= '0;
      pd[0] <= '0;
      pd[1] <= '0;
      pd[2] <= '0;
    end else begin
      pv    <= {pv[1:0], bq_valid_out};
      pd[0] <= stub_fn(cur_issue);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  end
  assign bq_valid_in = pv[2] | spur;
  assign bq_i_n      = pd[2][63:32];
  assign bq_y_n      = pd[2][31:0];

  // Reference model: per-band history arrays advanced one whole band at a time.
  logic [31:0] mx1, mx2;
  logic [31:0] mbi1 [NB], mbi2 [NB], mby1 [NB], mby2 [NB];
  logic [31:0] mli1 [NB], mli2 [NB], mly1 [NB], mly2 [NB];
  issue_t      exp_iss [2*NB];
  env_t        exp_env [NB];

  task automatic model_clear();
    mx1 = '0;
    mx2 = '0;
    for (int b = 0; b < NB; b++) begin
      mbi1[b] = '0; mbi2[b] = '0; mby1[b] = '0; mby2[b] = '0;
      mli1[b] = '0; mli2[b] = '0; mly1[b] = '0; mly2[b] = '0;
    end
  endtask

  task automatic model_frame(input logic [31:0] s);
    issue_t      bpf_r, lpf_r;
    logic [63:0] rb, rl;
    for (int b = 0; b < NB; b++) begin
      bpf_r = {4'(b), 5'd20, s, mx1, mx2, mbi1[b], mbi2[b], mby1[b], mby2[b]};
      rb    = stub_fn(bpf_r);
      lpf_r = {4'd8, 5'd8, sabs(rb[31:0]), sabs(mby1[b]), sabs(mby2[b]),
               mli1[b], mli2[b], mly1[b], mly2[b]};
      rl    = stub_fn(lpf_r);
      exp_iss[2*b]   = bpf_r;
      exp_iss[2*b+1] = lpf_r;
      exp_env[b]     = {3'(b), rl[31:0]};
      mbi2[b] = mbi1[b]; mbi1[b] = rb[63:32];
      mby2[b] = mby1[b]; mby1[b] = rb[31:0];
      mli2[b] = mli1[b]; mli1[b] = rl[63:32];
      mly2[b] = mly1[b]; mly1[b] = rl[31:0];
    end
    mx2 = mx1;
    mx1 = s;
  endtask

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  issue_t got_iss[$];
  env_t   got_env[$];
  int     env_cyc[$];
  int     got_frame[$];

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bq_valid_out) got_iss.push_back(cur_issue);
    if (env_valid_out) begin
      got_env.push_back({env_band_out, env_out});
      env_cyc.push_back(cyc);
    end
    if (frame_done_out) got_frame.push_back(cyc);
  endtask

  task automatic clear_q();
    got_iss.delete();
    got_env.delete();
    env_cyc.delete();
    got_frame.delete();
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!ready_out && guard < 100) begin
      tick();
      guard++;
    end
    chk("ready_wait", 272'(ready_out), 272'(1));
  endtask

  // One sample end to end; noise drives ignored sample_valid and bq_valid_in pulses.
  task automatic run_frame(input logic [31:0] s, input bit noise);
    int acc;
    int guard;
    bit saw_ready;
    clear_q();
    wait_ready();
    sample_in    = s;
    sample_valid = 1'b1;
    acc          = cyc;
    tick();
    sample_valid = 1'b0;
    saw_ready    = 1'b0;
    guard        = 0;
    while (got_frame.size() == 0 && guard < 300) begin
      if (noise) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = $urandom;
        spur         = (bq_valid_out | env_valid_out) & 1'($urandom_range(0, 1));
      end
      tick();
      guard++;
      if (got_frame.size() == 0 && ready_out) saw_ready = 1'b1;
    end
    sample_valid = 1'b0;
    spur         = 1'b0;
    model_frame(s);
    chk("issue_count", 272'(got_iss.size()), 272'(2 * NB));
    chk("env_count", 272'(got_env.size()), 272'(NB));
    chk("frame_count", 272'(got_frame.size()), 272'(1));
    chk("ready_low_in_frame", 272'(saw_ready), 272'(0));
    for (int i = 0; i < got_iss.size() && i < 2 * NB; i++)
      chk($sformatf("issue%0d", i), 272'(got_iss[i]), 272'(exp_iss[i]));
    for (int b = 0; b < got_env.size() && b < NB; b++)
      chk($sformatf("env%0d", b), 272'({got_env[b], 32'(env_cyc[b] - acc)}),
          272'({exp_env[b], 32'(BAND_CYC * b + BAND_CYC)}));
    if (got_frame.size() > 0)
      chk("frame_latency", 272'(got_frame[0] - acc), 272'(NB * BAND_CYC));
  endtask

  task automatic do_clear(input bit with_valid);
    wait_ready();
    hist_clear   = 1'b1;
    sample_valid = with_valid;
    sample_in    = $urandom;
    tick();
    hist_clear   = 1'b0;
    sample_valid = 1'b0;
    chk("clear_priority", 272'({ready_out, bq_valid_out}), 272'(2'b10));
    model_clear();
  endtask

  function automatic logic [271:0] all_outs();
    return {ready_out, bq_valid_out, bq_coeff_sel_out, bq_shift_out, bq_x_n, bq_x_n1,
            bq_x_n2, bq_i_n1, bq_i_n2, bq_y_n1, bq_y_n2, env_out, env_band_out,
            env_valid_out, frame_done_out};
  endfunction

  vec_t tbl [8];

  initial begin
    int guard;
    logic [31:0] s;
    tbl[0] = '{32'(-5), 32'd5};
    tbl[1] = '{32'd7, 32'd7};
    tbl[2] = '{32'd0, 32'd0};
    tbl[3] = '{32'h8000_0000, 32'h7FFF_FFFF};
    tbl[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tbl[5] = '{32'(-1), 32'd1};
    tbl[6] = '{32'h1234_5678, 32'h1234_5678};
    tbl[7] = '{32'(-32'sh1234_5678), 32'h1234_5678};

    #12;
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    tick();
    chk("post_reset", 272'({ready_out, bq_valid_out}), 272'(2'b10));
    model_clear();

    // Pass-through stub: envelope equals |sample| on every band.
    for (int t = 0; t < 8; t++) begin
      run_frame(tbl[t].s, 1'b0);
      for (int b = 0; b < got_env.size() && b < NB; b++)
        chk($sformatf("tbl%0d_env%0d", t, b), 272'(got_env[b].val), 272'(tbl[t].env));
      if (t == 1) begin
        chk("second_bpf_hist", 272'((got_iss.size() > 0) ?
            {got_iss[0].xn1, got_iss[0].yn1, got_iss[0].yn2} : 96'd0),
            272'({32'(-5), 32'(-5), 32'd0}));
        chk("second_lpf_ops", 272'((got_iss.size() > 1) ?
            {got_iss[1].xn, got_iss[1].xn1, got_iss[1].yn1} : 96'd0),
            272'({32'd7, 32'd5, 32'd5}));
      end
    end

    // BPF result of 0x80000000 on band 3 must rectify to 0x7FFFFFFF.
    ovr_sel = 4'd3;
    run_frame(32'd100, 1'b0);
    chk("sat_abs_lpf_xn", 272'((got_iss.size() > 7) ? got_iss[7].xn : 32'd0), 272'(32'h7FFF_FFFF));
    ovr_sel = 4'hF;
    run_frame(32'd200, 1'b0);

    // Held sample_valid and spurious bq_valid_in outside the wait states.
    run_frame(32'(-77), 1'b1);

    // Asynchronous reset in band 3 LPF_WAIT.
    clear_q();
    wait_ready();
    sample_in    = 32'd33;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    guard = 0;
    while (got_iss.size() < 8 && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_band3_lpf", 272'(got_iss.size()), 272'(8));
    tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), '0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_reset2", 272'({ready_out, bq_valid_out}), 272'(2'b10));
    model_clear();
    run_frame(32'(-5), 1'b0);
    chk("after_reset_hist", 272'((got_iss.size() > 0) ?
        {got_iss[0].xn1, got_iss[0].xn2, got_iss[0].yn1} : {96{1'b1}}), '0);

    // hist_clear wins over a simultaneous sample and zeroes all history.
    run_frame(32'd1234, 1'b0);
    do_clear(1'b1);
    run_frame(32'(-5), 1'b0);
    chk("after_clear_hist", 272'((got_iss.size() > 1) ?
        {got_iss[0].xn1, got_iss[0].yn1, got_iss[1].xn1, got_iss[1].yn1} : {128{1'b1}}), '0);

    // Randomised samples with a non-trivial stub against the reference model.
    pass_mode = 1'b0;
    salt      = $urandom;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) do_clear(1'($urandom_range(0, 1)));
      s = $urandom;
      if ($urandom_range(0, 5) == 0) s = 32'h8000_0000;
      run_frame(s, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
